clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- Time-keeping and time-setting controller for the mm:ss display path.
- Holds the minute and second BCD fields and sequences them through three modes: run, set-minutes and set-seconds.
- Drives the 16-bit digit bus consumed by the display mux/scanner, plus a per-digit blank mask for blinking the field being edited.
- Timing comes from single-cycle enable pulses produced by the clock divider. No derived clocks are used.

Parameters:
- HOLD_TICKS, 8: tick_blink pulses btn_inc must be held before auto-repeat starts (used only with AUTO_REPEAT_EN).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- RESET  input  1  synchronous reset, active-high.
- tick_sec  input  1  one-cycle pulse at 1 Hz.
- tick_blink  input  1  one-cycle pulse at the blink rate, approx. 4 Hz.
- btn_mode  input  1  debounced, synchronized level of the mode button.
- btn_inc  input  1  debounced, synchronized level of the increment button.
- btn_clr  input  1  debounced, synchronized level of the clear button.
- digit_out  output  16  {min_tens, min_ones, sec_tens, sec_ones}, each 4-bit BCD.
- blank_mask  output  4  1 = blank that digit; bit3 = min_tens ... bit0 = sec_ones.
- mode  output  2  00 RUN, 01 SET_MIN, 10 SET_SEC; 11 is never driven.
- hour_co  output  1  one-cycle pulse when 59:59 rolls over to 00:00 in RUN.

Behaviour:
- Reset values: digit_out = 16'h0000, blank_mask = 4'b0000, mode = RUN, hour_co = 0, blink phase = 0, hold counter = 0.
- Button edge detection:
  - Each button has a registered previous level. A rising edge = level & ~prev.
  - While RESET is high, each prev register loads the current level, so a button held across reset produces no edge.
- Mode FSM: a btn_mode edge steps RUN -> SET_MIN -> SET_SEC -> RUN. mode updates on the clock edge where the edge is detected (1-cycle latency from the button going high).
- RUN:
  - On tick_sec, seconds increment in BCD: ones 9 -> 0 carries into tens; 59 -> 00 carries into minutes.
  - Minutes 59 -> 00 pulses hour_co for exactly the one cycle of that update.
  - A btn_clr edge sets all digits to 0 and overrides a tick_sec in the same cycle. btn_inc is ignored.
- SET_MIN / SET_SEC:
  - tick_sec is ignored and time is frozen.
  - A btn_inc edge increments only the selected field, BCD mod 60 (59 -> 00). There is no carry into the other field and hour_co stays 0.
  - btn_clr zeroes only the selected field.
- Simultaneous events:
  - A mode edge together with an inc or clr edge: the mode change takes effect and the inc/clr is discarded.
  - inc and clr edges together: clr wins.
- Blink:
  - The phase toggles on each tick_blink while in a set state. The phase is forced to 0 on every mode change and while in RUN.
  - blank_mask = 4'b1100 in SET_MIN with phase 1, 4'b0011 in SET_SEC with phase 1, else 4'b0000.
  - The edited field is therefore visible immediately after entering a set state.
- Invariant: all outputs are registered and digit_out always holds valid BCD in 00..59 for both fields.
- Reset mid-operation (any mode, any cycle): next-cycle outputs equal the reset values. A pending hour_co is cancelled.

Optional Feature:
- Macro CLOCK_SET_AUTO_REPEAT_EN.
- Defined:
  - In a set state, while btn_inc stays high, a hold counter counts tick_blink pulses.
  - After HOLD_TICKS pulses, every further tick_blink produces one increment of the selected field.
  - The counter clears when btn_inc falls, on any mode change, and on reset.
  - If an increment edge and a repeat coincide, only one increment occurs.
- Undefined: increments occur only on btn_inc rising edges and the hold counter is not built.

Test Plan:
- RESET high 3 cycles with btn_mode held high, then release -> digit_out 16'h0000, mode 00, no mode change until btn_mode falls and rises again.
- RUN, preload 59:58 via set mode, 2 tick_sec pulses -> 16'h5959 then 16'h0000; hour_co high exactly on the second update cycle.
- btn_mode edge, then 3 btn_inc edges from 00:00 -> mode 01, digit_out 16'h0300; tick_sec pulses leave it unchanged; tick_blink toggles blank_mask 0000/1100.
- SET_SEC at 59 seconds, btn_inc edge -> seconds 00, minutes unchanged, hour_co 0; btn_mode edge -> RUN, blank_mask 0000.
- RUN at 12:34, btn_clr edge in the same cycle as tick_sec -> 16'h0000 next cycle.
- With CLOCK_SET_AUTO_REPEAT_EN, HOLD_TICKS = 8, hold btn_inc for 12 tick_blink pulses in SET_MIN from 00 -> minutes = 05 (1 edge + 4 repeats); without the macro -> 01.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// mm:ss time-keeping and time-setting controller for the display path.
// Optional build macro: CLOCK_SET_AUTO_REPEAT_EN (hold-to-repeat on btn_inc).
//
// Ports:
//   clk        system clock, rising edge
//   RESET      synchronous reset, active-high
//   tick_sec   1 Hz single-cycle enable
//   tick_blink blink-rate single-cycle enable
//   btn_mode   mode button level (debounced, synchronized)
//   btn_inc    increment button level
//   btn_clr    clear button level
//   digit_out  {min_tens, min_ones, sec_tens, sec_ones} BCD
//   blank_mask per-digit blank, bit3 = min_tens
//   mode       00 RUN, 01 SET_MIN, 10 SET_SEC
//   hour_co    one-cycle pulse on 59:59 -> 00:00 in RUN
module clock_set_ctrl #(
  parameter int HOLD_TICKS = 8
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        tick_sec,
  input  logic        tick_blink,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_clr,
  output logic [15:0] digit_out,
  output logic [3:0]  blank_mask,
  output logic [1:0]  mode,
  output logic        hour_co
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_MIN = 2'b01,
    SET_SEC = 2'b10
  } mode_e;

  mode_e       state_q, state_d;
  logic [7:0]  min_q, min_d;
  logic [7:0]  sec_q, sec_d;
  logic        hco_q, hco_d;
  logic        blink_q, blink_d;
  logic [3:0]  blank_q, blank_d;

  logic        mode_prev_q;
  logic        inc_prev_q;
  logic        clr_prev_q;
  logic        mode_ed;
  logic        inc_ed;
  logic        clr_ed;
  logic        rep;
  logic        inc_go;

  assign mode_ed = btn_mode & ~mode_prev_q;
  assign inc_ed  = btn_inc  & ~inc_prev_q;
  assign clr_ed  = btn_clr  & ~clr_prev_q;
  assign inc_go  = inc_ed | rep;

  // BCD increment, wrapping 59 -> 00.
  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v
  );
    logic [7:0] r;
    if (v == 8'h59) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam int HW = $clog2(HOLD_TICKS + 1);

  logic [HW-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    rep    = 1'b0;
    if (mode_ed || state_q == RUN || !btn_inc) begin
      hold_d = '0;
    end else if (tick_blink) begin
      // Counter saturates at HOLD_TICKS; each
      // further tick is one repeat increment.
      if (hold_q == HW'(HOLD_TICKS)) begin
        rep = 1'b1;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  logic unused_hold;
  assign unused_hold = ^HOLD_TICKS;
  assign rep = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    hco_d   = 1'b0;
    blink_d = blink_q;
    blank_d = 4'b0000;

    if (mode_ed) begin
      // Mode change swallows any inc/clr edge
      // and restarts the blink phase visible.
      blink_d = 1'b0;
      unique case (state_q)
        RUN:     state_d = SET_MIN;
        SET_MIN: state_d = SET_SEC;
        default: state_d = RUN;
      endcase
    end else begin
      unique case (state_q)
        RUN: begin
          blink_d = 1'b0;
          if (clr_ed) begin
            min_d = 8'h00;
            sec_d = 8'h00;
          end else if (tick_sec) begin
            sec_d = bcd_inc(sec_q);
            if (sec_q == 8'h59) begin
              min_d = bcd_inc(min_q);
              hco_d = (min_q == 8'h59);
            end
          end
        end
        SET_MIN: begin
          if (tick_blink) blink_d = ~blink_q;
          if (clr_ed) begin
            min_d = 8'h00;
          end else if (inc_go) begin
            min_d = bcd_inc(min_q);
          end
        end
        SET_SEC: begin
          if (tick_blink) blink_d = ~blink_q;
          if (clr_ed) begin
            sec_d = 8'h00;
          end else if (inc_go) begin
            sec_d = bcd_inc(sec_q);
          end
        end
        default: begin
          state_d = RUN;
          blink_d = 1'b0;
        end
      endcase
    end

    if (blink_d) begin
      if (state_d == SET_MIN) blank_d = 4'b1100;
      if (state_d == SET_SEC) blank_d = 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    // Prev levels track the buttons even in reset
    // so a button held across reset gives no edge.
    mode_prev_q <= btn_mode;
    inc_prev_q  <= btn_inc;
    clr_prev_q  <= btn_clr;
    if (RESET) begin
      state_q <= RUN;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      hco_q   <= 1'b0;
      blink_q <= 1'b0;
      blank_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      hco_q   <= hco_d;
      blink_q <= blink_d;
      blank_q <= blank_d;
    end
  end

  assign digit_out  = {min_q, sec_q};
  assign blank_mask = blank_q;
  assign mode       = state_q;
  assign hour_co    = hco_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl.
// Vector table plus hand sequences, scoreboard queue.
module tb_clock_set_ctrl;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        tsec = 1'b0;
  logic        tblk = 1'b0;
  logic        bm = 1'b0;
  logic        bi = 1'b0;
  logic        bc = 1'b0;
  logic [15:0] digit_out;
  logic [3:0]  blank_mask;
  logic [1:0]  mode;
  logic        hour_co;

  int errors = 0;
  int checks = 0;

  typedef logic [22:0] exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        m;
    logic        i;
    logic        c;
    logic        s;
    logic        bl;
    logic [15:0] d;
    logic [3:0]  b;
    logic [1:0]  md;
    logic        h;
  } vec_t;

  vec_t tbl[14];

  clock_set_ctrl #(.HOLD_TICKS(8)) dut (
    .clk        (clk),
    .RESET      (RESET),
    .tick_sec   (tsec),
    .tick_blink (tblk),
    .btn_mode   (bm),
    .btn_inc    (bi),
    .btn_clr    (bc),
    .digit_out  (digit_out),
    .blank_mask (blank_mask),
    .mode       (mode),
    .hour_co    (hour_co)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic step(
    input string       nm,
    input logic        m,
    input logic        i,
    input logic        c,
    input logic        s,
    input logic        bl,
    input logic [15:0] d,
    input logic [3:0]  b,
    input logic [1:0]  md,
    input logic        h
  );
    exp_t e;
    exp_t got;
    @(negedge clk);
    bm   = m;
    bi   = i;
    bc   = c;
    tsec = s;
    tblk = bl;
    exp_q.push_back({d, b, md, h});
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    got = {digit_out, blank_mask, mode, hour_co};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got digit=%h blank=%b mode=%b hco=%b, want digit=%h blank=%b mode=%b hco=%b",
               nm, got[22:7], got[6:3], got[2:1], got[0],
               e[22:7], e[6:3], e[2:1], e[0]);
    end
  endtask

  initial begin
    int em;
    // m i c s bl  digit  blank  mode h
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                16'h0000, 4'b0000, 2'd1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                16'h0100, 4'b0000, 2'd1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                16'h0100, 4'b0000, 2'd1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                16'h0200, 4'b0000, 2'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                16'h0200, 4'b0000, 2'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                16'h0300, 4'b0000, 2'd1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                16'h0300, 4'b0000, 2'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                16'h0300, 4'b0000, 2'd1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                16'h0300, 4'b1100, 2'd1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                16'h0300, 4'b1100, 2'd1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                16'h0300, 4'b0000, 2'd1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                16'h0300, 4'b1100, 2'd1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                16'h0000, 4'b1100, 2'd1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                16'h0000, 4'b1100, 2'd1, 1'b0};

    // Reset with btn_mode held: no edge afterwards.
    RESET = 1'b1;
    for (int k = 0; k < 3; k++)
      step("reset", 1, 0, 0, 0, 0,
           16'h0000, 4'b0000, 2'd0, 0);
    RESET = 1'b0;
    for (int k = 0; k < 2; k++)
      step("held_mode", 1, 0, 0, 0, 0,
           16'h0000, 4'b0000, 2'd0, 0);
    step("mode_fall", 0, 0, 0, 0, 0,
         16'h0000, 4'b0000, 2'd0, 0);

    foreach (tbl[k])
      step($sformatf("tbl%0d", k),
           tbl[k].m, tbl[k].i, tbl[k].c,
           tbl[k].s, tbl[k].bl, tbl[k].d,
           tbl[k].b, tbl[k].md, tbl[k].h);

    // Minutes through full wrap, then up to 59.
    for (int k = 1; k <= 119; k++) begin
      step("min_inc", 0, 1, 0, 0, 0,
           {bcd(k % 60), 8'h00}, 4'b1100, 2'd1, 0);
      step("min_rel", 0, 0, 0, 0, 0,
           {bcd(k % 60), 8'h00}, 4'b1100, 2'd1, 0);
    end

    step("to_sec", 1, 0, 0, 0, 0,
         16'h5900, 4'b0000, 2'd2, 0);
    step("to_sec_rel", 0, 0, 0, 0, 0,
         16'h5900, 4'b0000, 2'd2, 0);
    for (int k = 1; k <= 59; k++) begin
      step("sec_inc", 0, 1, 0, 0, 0,
           {8'h59, bcd(k)}, 4'b0000, 2'd2, 0);
      step("sec_rel", 0, 0, 0, 0, 0,
           {8'h59, bcd(k)}, 4'b0000, 2'd2, 0);
    end
    step("sec_wrap", 0, 1, 0, 0, 0,
         16'h5900, 4'b0000, 2'd2, 0);
    step("sec_wrap_rel", 0, 0, 0, 0, 0,
         16'h5900, 4'b0000, 2'd2, 0);
    for (int k = 1; k <= 58; k++) begin
      step("sec_inc2", 0, 1, 0, 0, 0,
           {8'h59, bcd(k)}, 4'b0000, 2'd2, 0);
      step("sec_rel2", 0, 0, 0, 0, 0,
           {8'h59, bcd(k)}, 4'b0000, 2'd2, 0);
    end

    step("to_run", 1, 0, 0, 0, 0,
         16'h5958, 4'b0000, 2'd0, 0);
    step("to_run_rel", 0, 0, 0, 0, 0,
         16'h5958, 4'b0000, 2'd0, 0);
    step("run_5959", 0, 0, 0, 1, 0,
         16'h5959, 4'b0000, 2'd0, 0);
    step("run_rollover", 0, 0, 0, 1, 0,
         16'h0000, 4'b0000, 2'd0, 1);
    step("hco_once", 0, 0, 0, 0, 0,
         16'h0000, 4'b0000, 2'd0, 0);

    // RUN counting with minute carry up to 12:34.
    for (int k = 1; k <= 754; k++)
      step("run_tick", 0, 0, 0, 1, 0,
           {bcd(k / 60), bcd(k % 60)},
           4'b0000, 2'd0, 0);
    step("clr_vs_tick", 0, 0, 1, 1, 0,
         16'h0000, 4'b0000, 2'd0, 0);
    step("clr_rel", 0, 0, 0, 0, 0,
         16'h0000, 4'b0000, 2'd0, 0);

    // Mode edge beats inc; clr beats inc.
    step("mode_and_inc", 1, 1, 0, 0, 0,
         16'h0000, 4'b0000, 2'd1, 0);
    step("mi_rel", 0, 0, 0, 0, 0,
         16'h0000, 4'b0000, 2'd1, 0);
    step("inc1", 0, 1, 0, 0, 0,
         16'h0100, 4'b0000, 2'd1, 0);
    step("inc1_rel", 0, 0, 0, 0, 0,
         16'h0100, 4'b0000, 2'd1, 0);
    step("inc_and_clr", 0, 1, 1, 0, 0,
         16'h0000, 4'b0000, 2'd1, 0);
    step("ic_rel", 0, 0, 0, 0, 0,
         16'h0000, 4'b0000, 2'd1, 0);
    step("inc2", 0, 1, 0, 0, 0,
         16'h0100, 4'b0000, 2'd1, 0);
    step("inc2_rel", 0, 0, 0, 0, 0,
         16'h0100, 4'b0000, 2'd1, 0);
    step("mode_and_clr", 1, 0, 1, 0, 0,
         16'h0100, 4'b0000, 2'd2, 0);
    step("mc_rel", 0, 0, 0, 0, 0,
         16'h0100, 4'b0000, 2'd2, 0);
    step("sec_blink", 0, 0, 0, 0, 1,
         16'h0100, 4'b0011, 2'd2, 0);

    // Reset mid-operation.
    RESET = 1'b1;
    step("mid_reset", 0, 0, 0, 0, 0,
         16'h0000, 4'b0000, 2'd0, 0);
    RESET = 1'b0;

    // Hold btn_inc over 12 blink ticks in SET_MIN.
    step("ar_mode", 1, 0, 0, 0, 0,
         16'h0000, 4'b0000, 2'd1, 0);
    step("ar_mode_rel", 0, 0, 0, 0, 0,
         16'h0000, 4'b0000, 2'd1, 0);
    step("ar_edge", 0, 1, 0, 0, 0,
         16'h0100, 4'b0000, 2'd1, 0);
    for (int p = 1; p <= 12; p++) begin
`ifdef CLOCK_SET_AUTO_REPEAT_EN
      em = 1 + ((p > 8) ? p - 8 : 0);
`else
      em = 1;
`endif
      step("ar_tick", 0, 1, 0, 0, 1,
           {bcd(em), 8'h00},
           (p % 2 == 1) ? 4'b1100 : 4'b0000,
           2'd1, 0);
      step("ar_gap", 0, 1, 0, 0, 0,
           {bcd(em), 8'h00},
           (p % 2 == 1) ? 4'b1100 : 4'b0000,
           2'd1, 0);
    end
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    step("ar_final", 0, 0, 0, 0, 0,
         16'h0500, 4'b0000, 2'd1, 0);
`else
    step("ar_final", 0, 0, 0, 0, 0,
         16'h0100, 4'b0000, 2'd1, 0);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
